// File: rtl/soc_pkg.sv
// Shared SoC types and default sizes for the core-to-memory arbitration path.
package soc_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_MEM_DEPTH  = 64;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

   typedef enum logic {
      OWN_IF,
      OWN_LS
   } owner_t;

endpackage

// File: rtl/mem_rr_arb.sv
// Two-way winner select (IF vs LS) with round-robin or LS-priority tie breaking.
module mem_rr_arb
   import soc_pkg::*;
#(
   parameter int LS_PRIORITY = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       if_valid_i,
   input  logic       ls_valid_i,
   input  logic       accept_i,
   output logic [1:0] grant_o
);

   owner_t last_grant_q, last_grant_d;

   // grant_o[0] = IF, grant_o[1] = LS; on a round-robin tie the non-last requester wins.
   always_comb begin
      grant_o = 2'b00;
      if (ls_valid_i && ((LS_PRIORITY != 0) || !if_valid_i || (last_grant_q == OWN_IF))) begin
         grant_o = 2'b10;
      end else if (if_valid_i) begin
         grant_o = 2'b01;
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (accept_i) begin
         last_grant_d = grant_o[1] ? OWN_LS : OWN_IF;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= OWN_LS;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single data-memory port between instruction fetch and load/store,
// one transaction in flight, with a per-transaction ack timeout.
module mem_arbiter
   import soc_pkg::*;
#(
   parameter  int MEM_DEPTH   = DEF_MEM_DEPTH,
   parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter  int TIMEOUT     = 16,
   parameter  int LS_PRIORITY = 0,
   localparam int ADDR_WIDTH  = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_req_valid,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_req_ready,
   output logic                  if_rsp_valid,
   output logic [DATA_WIDTH-1:0] if_rsp_data,
   output logic                  if_rsp_err,
   input  logic                  ls_req_valid,
   input  logic                  ls_we,
   input  logic [ADDR_WIDTH-1:0] ls_addr,
   input  logic [DATA_WIDTH-1:0] ls_wdata,
   output logic                  ls_req_ready,
   output logic                  ls_rsp_valid,
   output logic [DATA_WIDTH-1:0] ls_rsp_data,
   output logic                  ls_rsp_err,
   output logic                  mem_req_valid,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_valid_data
);

   localparam int                   CNT_WIDTH = $clog2(TIMEOUT + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(TIMEOUT - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(TIMEOUT);

   arb_state_t            state_q, state_d;
   owner_t                owner_q, owner_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  we_q, we_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  rsp_err_q, rsp_err_d;
   logic [1:0]            grant;
   logic                  accept;
   logic                  in_flight;

   // Gating with reset keeps the combinational readies low while reset is held.
   assign accept    = reset && (state_q == IDLE) && (grant != 2'b00);
   assign in_flight = (state_q == ISSUE) || (state_q == WAIT);

   mem_rr_arb #(
      .LS_PRIORITY(LS_PRIORITY)
   ) u_arb (
      .clk       (clk),
      .rst_n     (reset),
      .if_valid_i(if_req_valid),
      .ls_valid_i(ls_req_valid),
      .accept_i  (accept),
      .grant_o   (grant)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (mem_valid_data || (cnt_q == CNT_LAST)) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Holding registers, wait counter and response capture; an ack beats a coincident timeout.
   always_comb begin
      owner_d    = owner_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      if (accept) begin
         owner_d = grant[1] ? OWN_LS : OWN_IF;
         addr_d  = grant[1] ? ls_addr : if_addr;
         we_d    = grant[1] & ls_we;
         wdata_d = grant[1] ? ls_wdata : '0;
      end
      if (state_q == ISSUE) begin
         cnt_d = '0;
      end else if (state_q == WAIT) begin
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_WIDTH'(1);
         if (mem_valid_data) begin
            rsp_data_d = we_q ? '0 : mem_rdata;
            rsp_err_d  = 1'b0;
         end else if (cnt_q == CNT_LAST) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner_q    <= OWN_IF;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   always_comb begin
      if_req_ready  = accept & grant[0];
      ls_req_ready  = accept & grant[1];
      mem_req_valid = (state_q == ISSUE);
      mem_we        = in_flight ? we_q : 1'b0;
      mem_addr      = in_flight ? addr_q : '0;
      mem_wdata     = in_flight ? wdata_q : '0;
      if_rsp_valid  = 1'b0;
      if_rsp_data   = '0;
      if_rsp_err    = 1'b0;
      ls_rsp_valid  = 1'b0;
      ls_rsp_data   = '0;
      ls_rsp_err    = 1'b0;
      if (state_q == RESP) begin
         if (owner_q == OWN_LS) begin
            ls_rsp_valid = 1'b1;
            ls_rsp_data  = rsp_data_q;
            ls_rsp_err   = rsp_err_q;
         end else begin
            if_rsp_valid = 1'b1;
            if_rsp_data  = rsp_data_q;
            if_rsp_err   = rsp_err_q;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance plus an LS-priority twin on shared inputs.
module tb_mem_arbiter;

   localparam int AW      = 6;
   localparam int DW      = 32;
   localparam int TIMEOUT = 16;

   logic          clk;
   logic          reset;
   logic          if_req_valid;
   logic [AW-1:0] if_addr;
   logic          ls_req_valid;
   logic          ls_we;
   logic [AW-1:0] ls_addr;
   logic [DW-1:0] ls_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_valid_data;

   logic          if_req_ready, if_rsp_valid, if_rsp_err;
   logic [DW-1:0] if_rsp_data;
   logic          ls_req_ready, ls_rsp_valid, ls_rsp_err;
   logic [DW-1:0] ls_rsp_data;
   logic          mem_req_valid, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;

   logic          p_if_req_ready, p_if_rsp_valid, p_if_rsp_err;
   logic [DW-1:0] p_if_rsp_data;
   logic          p_ls_req_ready, p_ls_rsp_valid, p_ls_rsp_err;
   logic [DW-1:0] p_ls_rsp_data;
   logic          p_mem_req_valid, p_mem_we;
   logic [AW-1:0] p_mem_addr;
   logic [DW-1:0] p_mem_wdata;

   int checks   = 0;
   int failures = 0;

   mem_arbiter #(.MEM_DEPTH(64), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT), .LS_PRIORITY(0)) dut (
      .clk(clk), .reset(reset),
      .if_req_valid(if_req_valid), .if_addr(if_addr), .if_req_ready(if_req_ready),
      .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
      .ls_req_valid(ls_req_valid), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_req_ready(ls_req_ready), .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
      .ls_rsp_err(ls_rsp_err),
      .mem_req_valid(mem_req_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_valid_data(mem_valid_data)
   );

   mem_arbiter #(.MEM_DEPTH(64), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT), .LS_PRIORITY(1)) dut_pri (
      .clk(clk), .reset(reset),
      .if_req_valid(if_req_valid), .if_addr(if_addr), .if_req_ready(p_if_req_ready),
      .if_rsp_valid(p_if_rsp_valid), .if_rsp_data(p_if_rsp_data), .if_rsp_err(p_if_rsp_err),
      .ls_req_valid(ls_req_valid), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_req_ready(p_ls_req_ready), .ls_rsp_valid(p_ls_rsp_valid), .ls_rsp_data(p_ls_rsp_data),
      .ls_rsp_err(p_ls_rsp_err),
      .mem_req_valid(p_mem_req_valid), .mem_we(p_mem_we), .mem_addr(p_mem_addr),
      .mem_wdata(p_mem_wdata),
      .mem_rdata(mem_rdata), .mem_valid_data(mem_valid_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Runs one transaction starting at an IDLE negedge; k = ack cycle within WAIT, 0 = never.
   task automatic txn(input string tag, input bit is_ls, input bit we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input int k, input logic [DW-1:0] ack_data,
                      input logic [DW-1:0] exp_data, input bit exp_err);
      int n;
      logic busy_rsp;
      if (is_ls) begin
         ls_req_valid = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
      end else begin
         if_req_valid = 1'b1; if_addr = addr;
      end
      #1;
      check({tag, ":ready"}, is_ls ? ls_req_ready : if_req_ready, 1);
      check({tag, ":other_ready"}, is_ls ? if_req_ready : ls_req_ready, 0);
      @(negedge clk);
      // Scramble requester inputs: they must be ignored from here on.
      if_req_valid = 1'b0; ls_req_valid = 1'b0; ls_we = ~we;
      if_addr = ~addr; ls_addr = ~addr; ls_wdata = ~wdata;
      check({tag, ":issue_valid"}, mem_req_valid, 1);
      check({tag, ":issue_addr"}, mem_addr, addr);
      check({tag, ":issue_we"}, mem_we, we);
      if (we) check({tag, ":issue_wdata"}, mem_wdata, wdata);
      n = (k == 0) ? TIMEOUT : k;
      busy_rsp = 1'b0;
      for (int j = 1; j <= n; j++) begin
         @(negedge clk);
         if (j == 1) check({tag, ":req_one_cycle"}, mem_req_valid, 0);
         busy_rsp = busy_rsp | if_rsp_valid | ls_rsp_valid;
         if (k != 0 && j == k) begin
            mem_valid_data = 1'b1; mem_rdata = ack_data;
         end
      end
      check({tag, ":wait_addr_held"}, mem_addr, addr);
      check({tag, ":no_early_rsp"}, busy_rsp, 0);
      @(negedge clk);
      mem_valid_data = 1'b0; mem_rdata = '0;
      check({tag, ":rsp_valid"}, is_ls ? ls_rsp_valid : if_rsp_valid, 1);
      check({tag, ":rsp_data"}, is_ls ? ls_rsp_data : if_rsp_data, exp_data);
      check({tag, ":rsp_err"}, is_ls ? ls_rsp_err : if_rsp_err, exp_err);
      check({tag, ":other_rsp"}, is_ls ? if_rsp_valid : ls_rsp_valid, 0);
      @(negedge clk);
      check({tag, ":rsp_one_cycle"}, if_rsp_valid | ls_rsp_valid, 0);
      ls_we = 1'b0; if_addr = '0; ls_addr = '0; ls_wdata = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] exp_rr  [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
      logic [1:0] exp_pri [5] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
      logic       stale;

      reset = 1'b0; if_req_valid = 1'b0; if_addr = '0; ls_req_valid = 1'b0; ls_we = 1'b0;
      ls_addr = '0; ls_wdata = '0; mem_rdata = '0; mem_valid_data = 1'b0;

      // Reset state: no acceptance while reset is held, all outputs quiet.
      @(negedge clk);
      if_req_valid = 1'b1;
      #1;
      check("rst:if_ready", if_req_ready, 0);
      check("rst:mem_req", mem_req_valid, 0);
      check("rst:rsp", if_rsp_valid | ls_rsp_valid, 0);
      if_req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("idle:mem_addr", mem_addr, 0);
      check("idle:mem_we", mem_we, 0);
      @(negedge clk);

      // IF read, k=2.
      txn("if_read", 1'b0, 1'b0, 6'h05, '0, 2, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
      // LS store (ack data must be zeroed), then load back.
      txn("ls_store", 1'b1, 1'b1, 6'h3A, 32'h12345678, 1, 32'hFFFFFFFF, 32'h0, 1'b0);
      txn("ls_load", 1'b1, 1'b0, 6'h3A, '0, 3, 32'h12345678, 32'h12345678, 1'b0);

      // Timeout with no ack, then a late ack at ISSUE+20 that must be ignored.
      txn("timeout", 1'b0, 1'b0, 6'h11, '0, 0, '0, 32'h0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      mem_valid_data = 1'b1; mem_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      mem_valid_data = 1'b0; mem_rdata = '0;
      check("late_ack:rsp", if_rsp_valid | ls_rsp_valid, 0);
      check("late_ack:mem_req", mem_req_valid, 0);
      txn("after_late", 1'b0, 1'b0, 6'h12, '0, 1, 32'h0000CAFE, 32'h0000CAFE, 1'b0);

      // Ack on the final WAIT cycle beats the timeout.
      txn("ack_at_to", 1'b1, 1'b0, 6'h07, '0, TIMEOUT, 32'hA5A55A5A, 32'hA5A55A5A, 1'b0);

      // Asynchronous reset while in WAIT aborts without a response.
      if_req_valid = 1'b1; if_addr = 6'h2C;
      @(negedge clk);
      if_req_valid = 1'b0; if_addr = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_wait:addr_held", mem_addr, 6'h2C);
      #3 reset = 1'b0;
      #1;
      check("rst_wait:mem_addr", mem_addr, 0);
      check("rst_wait:outputs", {mem_req_valid, mem_we, if_rsp_valid, ls_rsp_valid, if_req_ready}, 0);
      @(negedge clk);
      reset = 1'b1;
      stale = 1'b0;
      for (int c = 0; c < TIMEOUT + 4; c++) begin
         @(negedge clk);
         stale = stale | if_rsp_valid | ls_rsp_valid | mem_req_valid;
      end
      check("rst_wait:no_stale", stale, 0);
      txn("post_rst", 1'b0, 1'b0, 6'h2D, '0, 2, 32'h01020304, 32'h01020304, 1'b0);

      // Arbitration: fresh last_grant, both requesters held; LS dropped for the fifth round.
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      if_req_valid = 1'b1; if_addr = 6'h10; ls_req_valid = 1'b1; ls_we = 1'b0; ls_addr = 6'h20;
      for (int t = 0; t < 5; t++) begin
         if (t == 4) ls_req_valid = 1'b0;
         #1;
         check($sformatf("arb%0d:rr_grant", t), {ls_req_ready, if_req_ready}, exp_rr[t]);
         check($sformatf("arb%0d:pri_grant", t), {p_ls_req_ready, p_if_req_ready}, exp_pri[t]);
         @(negedge clk);
         check($sformatf("arb%0d:rr_addr", t), mem_addr, exp_rr[t][1] ? 6'h20 : 6'h10);
         check($sformatf("arb%0d:pri_addr", t), p_mem_addr, exp_pri[t][1] ? 6'h20 : 6'h10);
         @(negedge clk);
         mem_valid_data = 1'b1; mem_rdata = 32'h100 + t;
         @(negedge clk);
         mem_valid_data = 1'b0; mem_rdata = '0;
         check($sformatf("arb%0d:rr_rsp", t), {ls_rsp_valid, if_rsp_valid}, exp_rr[t]);
         check($sformatf("arb%0d:pri_rsp", t), {p_ls_rsp_valid, p_if_rsp_valid}, exp_pri[t]);
         check($sformatf("arb%0d:rr_data", t), exp_rr[t][1] ? ls_rsp_data : if_rsp_data, 32'h100 + t);
         @(negedge clk);
      end
      if_req_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
